// File: rtl/int_ctrl_if.sv
// Bundle of the interrupt controller signals shared with the CPU side.
// The master side (CPU / IRQ sources) drives events, the mask and the
// acknowledge/return pulses. The slave side (int_ctrl) drives the request,
// the vector and the status views.
//
// Handshake: int_req acts as "valid" and int_ack as "ready". Once int_req
// rises it stays high, with int_vec constant, until the cycle in which
// int_ack is sampled high. The transfer completes on that clock edge and
// int_req is low in the following cycle. int_ack is ignored while int_req
// is low.
interface int_ctrl_if #(
    parameter int N_IRQ  = 4,
    parameter int ADDR_W = 16
);
    logic [N_IRQ-1:0]  irq;
    logic              ie_we;
    logic [N_IRQ-1:0]  ie_in;
    logic [N_IRQ-1:0]  pend_clr;
    logic              int_ack;
    logic              int_ret;
    logic              int_req;
    logic [ADDR_W-1:0] int_vec;
    logic [N_IRQ-1:0]  ie;
    logic [N_IRQ-1:0]  pending;
    logic [N_IRQ-1:0]  in_service;
    logic              bad_ret;
    // 1 while the request FSM is in its REQ state.
    logic              dbg_req_state;

    modport master (
        output irq, ie_we, ie_in, pend_clr, int_ack, int_ret,
        input  int_req, int_vec, ie, pending, in_service, bad_ret, dbg_req_state
    );

    modport slave (
        input  irq, ie_we, ie_in, pend_clr, int_ack, int_ret,
        output int_req, int_vec, ie, pending, in_service, bad_ret, dbg_req_state
    );
endinterface

// File: rtl/int_ctrl.sv
// Prioritised, nesting interrupt controller. Index 0 is the highest
// priority. Rising edges on irq are latched as pending bits. The lowest
// enabled pending index that beats every in-service level is offered to
// the CPU as a single request with a frozen vector. Acknowledge moves the
// source from pending to in-service. Return retires the innermost
// (highest-priority) in-service level.
module int_ctrl #(
    parameter int                N_IRQ      = 4,
    parameter int                ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] VEC_BASE   = 16'h0100,
    parameter logic [ADDR_W-1:0] VEC_STRIDE = 16'h0010
) (
    input  logic       clk,
    input  logic       reset,
    int_ctrl_if.slave  bus
);
    localparam int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    // Registered state
    state_t            state_q;
    logic [IDX_W-1:0]  idx_q;
    logic [ADDR_W-1:0] vec_q;
    logic              int_req_q;
    logic [N_IRQ-1:0]  irq_q;
    logic [N_IRQ-1:0]  ie_q,         ie_d;
    logic [N_IRQ-1:0]  pending_q,    pending_d;
    logic [N_IRQ-1:0]  in_service_q, in_service_d;
    logic              bad_ret_q,    bad_ret_d;

    // Combinational helpers
    logic [N_IRQ-1:0]  rise;
    logic [N_IRQ-1:0]  prio_mask;
    logic              blocked;
    logic [N_IRQ-1:0]  eligible;
    logic              cand_valid;
    logic [IDX_W-1:0]  cand_idx;
    logic [ADDR_W-1:0] cand_vec;
    logic              ack_fire;
    logic [N_IRQ-1:0]  ack_set;
    logic [N_IRQ-1:0]  ret_clr;

    // Edge detection and candidate selection. prio_mask keeps only the
    // indices strictly above (numerically below) the innermost active
    // service level, so equal or lower priorities never nest.
    always_comb begin
        rise      = bus.irq & ~irq_q;
        prio_mask = '0;
        blocked   = 1'b0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (in_service_q[i]) begin
                blocked = 1'b1;
            end
            if (!blocked) begin
                prio_mask[i] = 1'b1;
            end
        end
        eligible   = pending_q & ie_q & prio_mask;
        cand_valid = |eligible;
        cand_idx   = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                cand_idx = IDX_W'(i);
            end
        end
        // Vector math stays in ADDR_W bits; overflow wraps.
        cand_vec = VEC_BASE + ADDR_W'(cand_idx) * VEC_STRIDE;
    end

    // Next-state of the pending / in-service / mask / error bookkeeping.
    // A new rising edge wins over any clear hitting the same bit. A return
    // clears the lowest set in-service bit before the acknowledge sets its bit.
    always_comb begin
        ack_fire     = (state_q == S_REQ) && bus.int_ack;
        ack_set      = ack_fire ? (N_IRQ'(1) << idx_q) : '0;
        ret_clr      = bus.int_ret ? (in_service_q & (~in_service_q + 1'b1)) : '0;
        pending_d    = (pending_q & ~bus.pend_clr & ~ack_set) | rise;
        in_service_d = (in_service_q & ~ret_clr) | ack_set;
        ie_d         = bus.ie_we ? bus.ie_in : ie_q;
        bad_ret_d    = bad_ret_q | (bus.int_ret && (in_service_q == '0));
    end

    // Bookkeeping registers, including the irq history for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q        <= '0;
            ie_q         <= '0;
            pending_q    <= '0;
            in_service_q <= '0;
            bad_ret_q    <= 1'b0;
        end else begin
            irq_q        <= bus.irq;
            ie_q         <= ie_d;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            bad_ret_q    <= bad_ret_d;
        end
    end

    // Request FSM. Index and vector are captured on entry to REQ and held
    // until the acknowledge, whatever happens to pending/ie meanwhile.
    // Leaving REQ always passes through IDLE for at least one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            vec_q     <= VEC_BASE;
            int_req_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cand_valid) begin
                        state_q   <= S_REQ;
                        idx_q     <= cand_idx;
                        vec_q     <= cand_vec;
                        int_req_q <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (bus.int_ack) begin
                        state_q   <= S_IDLE;
                        int_req_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    int_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.int_req       = int_req_q;
    assign bus.int_vec       = vec_q;
    assign bus.ie            = ie_q;
    assign bus.pending       = pending_q;
    assign bus.in_service    = in_service_q;
    assign bus.bad_ret       = bad_ret_q;
    assign bus.dbg_req_state = (state_q == S_REQ);
endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_int_ctrl;
    localparam int N = 4;
    localparam int W = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic cmp_en = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    int_ctrl_if #(.N_IRQ(N), .ADDR_W(W)) bus ();

    int_ctrl #(.N_IRQ(N), .ADDR_W(W), .VEC_BASE(16'h0100), .VEC_STRIDE(16'h0010)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [N-1:0] m_irq_prev, m_pending, m_ie, m_isr;
    logic         m_req, m_bad;
    int           m_idx;
    logic [N-1:0] mr_rise, mr_p, mr_s;
    logic         mr_acked;
    int           mr_cand;

    function automatic int lowest_set(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return N;
    endfunction

    function automatic logic [W-1:0] exp_vec(input int idx);
        int v;
        v = 32'h0100 + idx * 32'h0010;
        return v[W-1:0];
    endfunction

    initial begin
        m_irq_prev = '0; m_pending = '0; m_ie = '0; m_isr = '0;
        m_req = 1'b0; m_bad = 1'b0; m_idx = 0;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_irq_prev = '0; m_pending = '0; m_ie = '0; m_isr = '0;
            m_req = 1'b0; m_bad = 1'b0; m_idx = 0;
        end else begin
            mr_rise  = bus.irq & ~m_irq_prev;
            mr_acked = m_req && bus.int_ack;
            // best enabled pending source that outranks all active services
            mr_cand = -1;
            for (int i = 0; i < N; i++)
                if (mr_cand < 0 && m_pending[i] && m_ie[i] && i < lowest_set(m_isr)) mr_cand = i;
            mr_s = m_isr;
            if (bus.int_ret) begin
                if (m_isr == '0) m_bad = 1'b1;
                else mr_s[lowest_set(m_isr)] = 1'b0;
            end
            if (mr_acked) mr_s[m_idx] = 1'b1;
            mr_p = m_pending & ~bus.pend_clr;
            if (mr_acked) mr_p[m_idx] = 1'b0;
            mr_p = mr_p | mr_rise;
            if (m_req) begin
                if (mr_acked) m_req = 1'b0;
            end else if (mr_cand >= 0) begin
                m_req = 1'b1;
                m_idx = mr_cand;
            end
            m_pending = mr_p;
            m_isr     = mr_s;
            if (bus.ie_we) m_ie = bus.ie_in;
            m_irq_prev = bus.irq;
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en && !reset) begin
            check("m_int_req", {31'b0, bus.int_req}, {31'b0, m_req});
            if (m_req) check("m_int_vec", {16'b0, bus.int_vec}, {16'b0, exp_vec(m_idx)});
            check("m_ie", {28'b0, bus.ie}, {28'b0, m_ie});
            check("m_pending", {28'b0, bus.pending}, {28'b0, m_pending});
            check("m_in_service", {28'b0, bus.in_service}, {28'b0, m_isr});
            check("m_bad_ret", {31'b0, bus.bad_ret}, {31'b0, m_bad});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_irq(input logic [N-1:0] v);
        bus.irq = v; tick(); bus.irq = '0;
    endtask

    task automatic do_ack();
        bus.int_ack = 1'b1; tick(); bus.int_ack = 1'b0;
    endtask

    task automatic do_ret();
        bus.int_ret = 1'b1; tick(); bus.int_ret = 1'b0;
    endtask

    task automatic write_ie(input logic [N-1:0] v);
        bus.ie_we = 1'b1; bus.ie_in = v; tick(); bus.ie_we = 1'b0;
    endtask

    task automatic apply_reset();
        bus.irq = '0; bus.ie_we = 1'b0; bus.ie_in = '0; bus.pend_clr = '0;
        bus.int_ack = 1'b0; bus.int_ret = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.irq = '0; bus.ie_we = 1'b0; bus.ie_in = '0; bus.pend_clr = '0;
        bus.int_ack = 1'b0; bus.int_ret = 1'b0;
        #1;
        apply_reset();
        check("rst_int_req", {31'b0, bus.int_req}, 32'd0);
        check("rst_int_vec", {16'b0, bus.int_vec}, 32'h0100);
        check("rst_bad_ret", {31'b0, bus.bad_ret}, 32'd0);
        cmp_en = 1'b1;

        // 1: single source, latency and vector
        write_ie(4'b1111);
        pulse_irq(4'b0100);
        check("t1_pending", {28'b0, bus.pending}, 32'h4);
        check("t1_req_early", {31'b0, bus.int_req}, 32'd0);
        tick();
        check("t1_req", {31'b0, bus.int_req}, 32'd1);
        check("t1_vec", {16'b0, bus.int_vec}, 32'h0120);
        do_ack();
        check("t1_isr", {28'b0, bus.in_service}, 32'h4);
        check("t1_req_drop", {31'b0, bus.int_req}, 32'd0);
        do_ret();
        check("t1_isr_ret", {28'b0, bus.in_service}, 32'h0);

        // 2: simultaneous edges, lower priority held off until return
        pulse_irq(4'b1010);
        tick();
        check("t2_vec", {16'b0, bus.int_vec}, 32'h0110);
        do_ack();
        check("t2_isr", {28'b0, bus.in_service}, 32'h2);
        check("t2_pending", {28'b0, bus.pending}, 32'h8);
        repeat (3) tick();
        check("t2_held", {31'b0, bus.int_req}, 32'd0);
        do_ret();
        tick();
        check("t2_req3", {31'b0, bus.int_req}, 32'd1);
        check("t2_vec3", {16'b0, bus.int_vec}, 32'h0130);
        do_ack();
        do_ret();

        // 3: nesting a higher priority source
        pulse_irq(4'b0100);
        tick();
        do_ack();
        check("t3_isr2", {28'b0, bus.in_service}, 32'h4);
        pulse_irq(4'b0001);
        tick();
        check("t3_nest_req", {31'b0, bus.int_req}, 32'd1);
        check("t3_nest_vec", {16'b0, bus.int_vec}, 32'h0100);
        do_ack();
        check("t3_isr_both", {28'b0, bus.in_service}, 32'h5);
        do_ret();
        check("t3_ret_bit0", {28'b0, bus.in_service}, 32'h4);
        do_ret();

        // 4: masked source latches, request follows the mask write
        write_ie(4'b0000);
        pulse_irq(4'b0010);
        check("t4_pending", {28'b0, bus.pending}, 32'h2);
        repeat (2) tick();
        check("t4_masked", {31'b0, bus.int_req}, 32'd0);
        write_ie(4'b0010);
        check("t4_not_yet", {31'b0, bus.int_req}, 32'd0);
        tick();
        check("t4_req", {31'b0, bus.int_req}, 32'd1);
        check("t4_vec", {16'b0, bus.int_vec}, 32'h0110);
        do_ack();
        do_ret();

        // 5: request frozen while a higher priority arrives
        write_ie(4'b1111);
        pulse_irq(4'b1000);
        tick();
        check("t5_vec3", {16'b0, bus.int_vec}, 32'h0130);
        pulse_irq(4'b0001);
        tick();
        check("t5_frozen_req", {31'b0, bus.int_req}, 32'd1);
        check("t5_frozen_vec", {16'b0, bus.int_vec}, 32'h0130);
        do_ack();
        check("t5_idle_gap", {31'b0, bus.int_req}, 32'd0);
        tick();
        check("t5_req0", {31'b0, bus.int_req}, 32'd1);
        check("t5_vec0", {16'b0, bus.int_vec}, 32'h0100);
        do_ack();
        check("t5_isr", {28'b0, bus.in_service}, 32'h9);
        do_ret();
        do_ret();

        // 6: bad return is sticky; async reset during REQ
        do_ret();
        check("t6_bad", {31'b0, bus.bad_ret}, 32'd1);
        repeat (2) tick();
        check("t6_bad_sticky", {31'b0, bus.bad_ret}, 32'd1);
        pulse_irq(4'b0010);
        tick();
        check("t6_req", {31'b0, bus.int_req}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("t6_rst_req", {31'b0, bus.int_req}, 32'd0);
        check("t6_rst_vec", {16'b0, bus.int_vec}, 32'h0100);
        check("t6_rst_ie", {28'b0, bus.ie}, 32'h0);
        check("t6_rst_pend", {28'b0, bus.pending}, 32'h0);
        check("t6_rst_isr", {28'b0, bus.in_service}, 32'h0);
        check("t6_rst_bad", {31'b0, bus.bad_ret}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // randomized traffic, occasional reset to clear sticky state
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc % 1000 == 999) apply_reset();
            bus.irq      = N'($urandom_range(0, 15));
            bus.ie_we    = ($urandom_range(0, 11) == 0);
            bus.ie_in    = N'($urandom_range(0, 15));
            bus.pend_clr = ($urandom_range(0, 7) == 0) ? N'($urandom_range(0, 15)) : '0;
            bus.int_ack  = bus.int_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            bus.int_ret  = ($urandom_range(0, 9) == 0);
            tick();
        end
        bus.irq = '0; bus.ie_we = 1'b0; bus.pend_clr = '0;
        bus.int_ack = 1'b0; bus.int_ret = 1'b0;
        tick();
        cmp_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
